// File: rtl/ysyx_040729_mem_arbiter.sv
// Purpose: arbitrates one downstream bus between instruction fetch (IF) and load/store (MEM).
// Latency: request seen in IDLE at cycle t -> bus_valid at t+1; ready is combinational with bus_ready.
// Backpressure: requesters hold valid until their ready pulse; bus_ready stalls the granted transaction.
module ysyx_040729_mem_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int INST_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [INST_WIDTH-1:0] if_data_read,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data_write,
  input  logic [2:0]            mem_size,
  input  logic                  mem_wen,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_data_read,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [2:0]            bus_size,
  output logic                  bus_wen,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic [1:0]            bus_owner
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  // State encoding doubles as the bus_owner code.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT_IF  = 2'b01,
    GNT_MEM = 2'b10
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           starve_q, starve_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [2:0]              size_q, size_d;
  logic                    wen_q, wen_d;
  logic                    if_sel_hi;

  // Next-state and request latching: MEM wins ties unless IF has waited STARVE_LIMIT grants.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    wen_d    = wen_q;
    case (state_q)
      IDLE: begin
        if (mem_valid && (!if_valid || (starve_q != LIMIT_C))) begin
          state_d = GNT_MEM;
          addr_d  = mem_addr;
          wdata_d = mem_data_write;
          size_d  = mem_size;
          wen_d   = mem_wen;
          if (if_valid && (starve_q != LIMIT_C)) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (if_valid) begin
          state_d  = GNT_IF;
          addr_d   = if_addr;
          wdata_d  = '0;
          size_d   = 3'b010;
          wen_d    = 1'b0;
          starve_d = '0;
        end
      end
      GNT_IF, GNT_MEM: begin
        if (bus_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: bus side comes only from latched registers; ready is masked by reset so an
  // abandoned transaction never completes.
  always_comb begin
    bus_valid     = (state_q != IDLE);
    bus_owner     = state_q;
    bus_addr      = addr_q;
    bus_wdata     = wdata_q;
    bus_size      = size_q;
    bus_wen       = wen_q;
    if_ready      = (state_q == GNT_IF) && bus_ready && !reset;
    mem_ready     = (state_q == GNT_MEM) && bus_ready && !reset;
    if_sel_hi     = addr_q[2];
    mem_data_read = mem_ready ? bus_rdata : '0;
    if_data_read  = '0;
    if (if_ready) begin
      if_data_read = if_sel_hi ? bus_rdata[2*INST_WIDTH-1:INST_WIDTH]
                               : bus_rdata[INST_WIDTH-1:0];
    end
  end

  // State, starvation counter and latched bus request registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      wen_q    <= wen_d;
    end
  end

endmodule

// File: doc/ysyx_040729_mem_arbiter.md
YSYX_040729_MEM_ARBITER -- requirements
Module: ysyx_040729_mem_arbiter

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 64, bus data width; ADDR_WIDTH, default 32, address width; INST_WIDTH, default 32, fetch word width; STARVE_LIMIT, default 4, maximum consecutive MEM grants while IF waits.
REQ-002 SHALL have ports, clock and reset first:
  clock           in   1           sole clock, rising edge
  reset           in   1           synchronous, active-high
  if_valid        in   1           fetch request, held until if_ready
  if_addr         in   ADDR_WIDTH  fetch address
  if_ready        out  1           fetch complete pulse
  if_data_read    out  INST_WIDTH  fetched instruction
  mem_valid       in   1           load/store request, held until mem_ready
  mem_addr        in   ADDR_WIDTH  load/store address
  mem_data_write  in   DATA_WIDTH  store data
  mem_size        in   3           funct3 access size
  mem_wen         in   1           1 = store
  mem_ready       out  1           load/store complete pulse
  mem_data_read   out  DATA_WIDTH  load data
  bus_valid       out  1           downstream request
  bus_ready       in   1           downstream completion
  bus_addr        out  ADDR_WIDTH  downstream address
  bus_wdata       out  DATA_WIDTH  downstream store data
  bus_size        out  3           downstream size
  bus_wen         out  1           downstream write enable
  bus_rdata       in   DATA_WIDTH  downstream read data
  bus_owner       out  2           00 none, 01 IF, 10 MEM
REQ-003 SHALL use one clock (clock); reset is synchronous and active-high (reset).

Function
REQ-004 SHALL implement FSM states IDLE, GNT_IF, GNT_MEM; bus_owner encodes state (IDLE=00, GNT_IF=01, GNT_MEM=10).
REQ-005 IDLE: no request -> stay; only if_valid -> GNT_IF; only mem_valid -> GNT_MEM; both -> GNT_MEM unless starve counter == STARVE_LIMIT, then GNT_IF.
REQ-006 On IDLE->GNT_x transition SHALL latch winning requester's addr (and for MEM: wdata, size, wen) into bus registers; bus outputs driven only from latched values.
REQ-007 IF grant SHALL drive bus_size=3'b010, bus_wen=0, bus_wdata=0.
REQ-008 bus_valid SHALL be 1 exactly while state is GNT_IF or GNT_MEM.
REQ-009 In GNT_x with bus_ready=1: x_ready=1 combinationally in that same cycle; next state IDLE; other requester's ready stays 0.
REQ-010 mem_data_read SHALL equal bus_rdata when mem_ready=1, else 0.
REQ-011 if_data_read SHALL equal bus_rdata[63:32] when latched addr bit 2 = 1, else bus_rdata[31:0], when if_ready=1; else 0.
REQ-012 Latency: request seen in IDLE at cycle t -> bus_valid at t+1; ready no earlier than t+1; one IDLE cycle between consecutive grants.
REQ-013 Requester valid deasserting during its grant SHALL NOT abort; transaction completes and ready still pulses.
REQ-014 Requester inputs changing during grant SHALL NOT alter bus outputs.
REQ-015 Starve counter (width clog2(STARVE_LIMIT+1)): +1 on each MEM grant taken while if_valid=1; cleared on any IF grant; saturates at STARVE_LIMIT.
REQ-016 bus_ready while IDLE SHALL be ignored (no ready pulse, no state change).

Reset
REQ-017 On reset: state IDLE, bus_valid=0, bus_owner=00, if_ready=0, mem_ready=0, bus_addr/bus_wdata/bus_size/bus_wen=0, starve counter=0.
REQ-018 Reset during GNT_x SHALL abandon the transaction: no ready pulse; bus_valid=0 the cycle after reset is sampled.

Verification
REQ-019 mem_valid=1, mem_addr=0x80001000, mem_wen=1, size=3, bus_ready=1 one cycle after grant -> bus_valid at t+1 with bus_addr=0x80001000, bus_wen=1; mem_ready pulse 1 cycle; bus_owner 10 then 00.
REQ-020 if_valid=1, if_addr=0x80000004, bus_rdata=0x11223344_00000013 -> if_data_read=0x11223344, bus_size=010, bus_wen=0.
REQ-021 if_valid and mem_valid both held continuously, bus_ready=1 always -> grant order MEM,MEM,MEM,MEM,IF,MEM,... (STARVE_LIMIT=4), one IDLE between each.
REQ-022 GNT_MEM with bus_ready=0 for 5 cycles while mem_addr changes -> bus_addr stable at latched value; mem_ready only on 6th cycle when bus_ready=1.
REQ-023 reset asserted for 1 cycle during GNT_IF with bus_ready=0 -> next cycle bus_valid=0, if_ready never pulses, counter=0.
REQ-024 bus_ready=1 in IDLE with no requests -> all outputs remain at reset values.
